// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and the baud divider
// helper that both the receiver and transmitter baud logic use.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Clocks per oversample tick; integer division, so non-exact rates round down.
    function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks. A synchronous
// restart zeroes the count so the tick phase lines up with a detected start bit.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_baud_tick: DIV must be >= 1 (clock too slow for BAUD*OVERSAMPLE)");
        end
    endgenerate

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver, 8 data bits LSB first, oversampled with 3-sample majority voting.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   UART_RX,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   rx_int,
    output logic                   frame_err,
    output logic                   parity_err
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(UART_DATA_W);
    localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_MID_LO = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_MID    = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] OS_MID_HI = OSW'(OVERSAMPLE / 2 + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(UART_DATA_W - 1);

    generate
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("uart_rx_core: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    uart_state_e            state, state_d;
    logic                   sync1, sync2, rx_d;
    logic [OSW-1:0]         os_cnt, os_d;
    logic [BCW-1:0]         bit_cnt, bit_d;
    logic [UART_DATA_W-1:0] shreg, shreg_d, rx_data_d;
    logic [1:0]             samp, samp_d;
    logic                   valid_d, ferr_d, int_d;
    logic                   restart, tick;
    logic                   line, fall, os_wrap, decide, maj;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign line    = sync2;
    assign fall    = rx_d & ~sync2;
    assign os_wrap = tick && (os_cnt == OS_LAST);
    assign decide  = tick && (os_cnt == OS_MID_HI);
    // The third vote is the live sample, so the decision lands on the OS_MID_HI tick.
    assign maj     = (samp[0] & samp[1]) | (samp[0] & line) | (samp[1] & line);

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d, perr_pulse, perr_pulse_d;
    assign parity_err = perr_pulse;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        os_d      = os_cnt;
        bit_d     = bit_cnt;
        shreg_d   = shreg;
        samp_d    = samp;
        rx_data_d = rx_data;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        int_d     = rx_int;
        restart   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
        perr_pulse_d = 1'b0;
`endif

        if (tick && state != IDLE && state != BREAK) begin
            os_d = os_wrap ? '0 : os_cnt + 1'b1;
        end
        if (tick && os_cnt == OS_MID_LO) samp_d[0] = line;
        if (tick && os_cnt == OS_MID)    samp_d[1] = line;

        case (state)
            IDLE: begin
                if (fall) begin
                    restart = 1'b1;
                    os_d    = '0;
                    bit_d   = '0;
                    int_d   = 1'b1;
                    state_d = START;
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (tick && os_cnt == OS_MID && line) begin
                    int_d   = 1'b0;
                    state_d = IDLE;
                end else if (os_wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) shreg_d[bit_cnt] = maj;
                if (os_wrap) begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) perr_d = maj ^ (^shreg);
                if (os_wrap) state_d = STOP;
            end
`endif
            STOP: begin
                if (decide) begin
                    int_d = 1'b0;
                    if (maj) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (perr_q) begin
                            perr_pulse_d = 1'b1;
                        end else begin
                            valid_d   = 1'b1;
                            rx_data_d = shreg;
                        end
`else
                        valid_d   = 1'b1;
                        rx_data_d = shreg;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            rx_d      <= 1'b1;
            state     <= IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            samp      <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_int    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            perr_pulse <= 1'b0;
`endif
        end else begin
            sync1     <= UART_RX;
            sync2     <= sync1;
            rx_d      <= sync2;
            state     <= state_d;
            os_cnt    <= os_d;
            bit_cnt   <= bit_d;
            shreg     <= shreg_d;
            samp      <= samp_d;
            rx_data   <= rx_data_d;
            rx_valid  <= valid_d;
            frame_err <= ferr_d;
            rx_int    <= int_d;
`ifdef UART_RX_PARITY_EN
            perr_q     <= perr_d;
            perr_pulse <= perr_pulse_d;
`endif
        end
    end

endmodule
